// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, fetch entry type and fetch FSM states
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_e;

  // Instruction fetches are always word aligned; low two bits are forced to zero.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory, redirect and decode handshake bundle
interface instr_fetch_unit_if;
  import riscv_pkg::*;

  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [ILEN-1:0] imem_rdata_i;
  logic            instr_valid_o;
  logic [ILEN-1:0] instr_o;
  logic [XLEN-1:0] pc_o;
  logic            instr_ready_i;

  modport master (
    input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// rtl/instr_fetch_unit_fetch_fifo.sv - small synchronous FIFO of {pc, instr} entries with flush
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is read straight from storage; an empty FIFO presents zeros rather than stale data.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage and pointer update; flush discards everything and wins over a same-cycle push.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch front end: credit-limited requests, response buffering, redirect
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                 clk_i,
  input logic                 rstn_i,
  instr_fetch_unit_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outs_q, outs_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic            redir_pend_q, redir_pend_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;

  logic            req;
  logic            gnt;
  logic            push;
  logic            pop;
  logic            stall_req;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   count_d;
  logic [CW:0]     occupancy;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign req       = (state_q == FETCH_REQ);
  assign gnt       = req && bus.imem_gnt_i;
  assign stall_req = req && !bus.imem_gnt_i;
  assign target    = align_word(bus.redirect_pc_i);
  assign pop       = !fifo_empty && bus.instr_ready_i;
  // Responses are stale while discard is non-zero, and anything arriving with a redirect is dropped.
  assign push      = bus.imem_rvalid_i && (discard_q == '0) && !bus.redirect_i;
  assign push_entry = '{pc: rsp_pc_q, instr: bus.imem_rdata_i};

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = !fifo_empty;
  assign bus.instr_o       = head.instr;
  assign bus.pc_o          = head.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (push),
    .pop    (pop),
    .flush  (bus.redirect_i),
    .wdata  (push_entry),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Next-state for request FSM, PCs and in-flight bookkeeping.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    rsp_pc_d     = rsp_pc_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    discard_d    = discard_q;

    outs_d  = outs_q + CW'(gnt) - CW'(bus.imem_rvalid_i);
    count_d = bus.redirect_i ? '0 : (fifo_count + CW'(push) - CW'(pop));
    occupancy = {1'b0, count_d} + {1'b0, outs_d};

    // A request left waiting for gnt cannot move, so a redirect arriving then is parked until it is granted.
    if (bus.redirect_i) begin
      rsp_pc_d  = target;
      discard_d = outs_d + CW'(stall_req);
      if (stall_req) begin
        redir_pend_d = 1'b1;
        redir_pc_d   = target;
      end else begin
        fetch_pc_d   = target;
        redir_pend_d = 1'b0;
      end
    end else begin
      if (bus.imem_rvalid_i && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
      end
      if (gnt) begin
        if (redir_pend_q) begin
          fetch_pc_d   = redir_pc_q;
          redir_pend_d = 1'b0;
        end else begin
          fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
      end
    end

    case (state_q)
      FETCH_REQ: begin
        if (gnt) begin
          state_d = (occupancy < (CW+1)'(DEPTH)) ? FETCH_REQ : FETCH_IDLE;
        end
      end
      default: begin
        state_d = (occupancy < (CW+1)'(DEPTH)) ? FETCH_REQ : FETCH_IDLE;
      end
    endcase
  end

  // State register for the FSM and all fetch bookkeeping.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= FETCH_IDLE;
      fetch_pc_q   <= RESET_PC;
      rsp_pc_q     <= RESET_PC;
      outs_q       <= '0;
      discard_q    <= '0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      rsp_pc_q     <= rsp_pc_d;
      outs_q       <= outs_d;
      discard_q    <= discard_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst2_n;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   gnt_budget = 0;
  int   rsp_budget = 0;

  logic [31:0] q1[$];
  logic [31:0] gnt_addr[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];
  int          got_cyc[$];
  logic [31:0] q2[$];
  logic [31:0] got2_pc[$];

  instr_fetch_unit_if if1();
  instr_fetch_unit_if if2();

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i (clk), .rstn_i (rst_n), .bus (if1.master)
  );

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk_i (clk), .rstn_i (rst2_n), .bus (if2.master)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  // Memory model and output monitor for dut: budgets throttle grants and responses.
  initial begin
    logic [31:0] a;
    if1.imem_gnt_i = 1'b0; if1.imem_rvalid_i = 1'b0; if1.imem_rdata_i = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        q1.delete();
        if1.imem_gnt_i = 1'b0; if1.imem_rvalid_i = 1'b0; if1.imem_rdata_i = '0;
      end else begin
        if (if1.instr_valid_o && if1.instr_ready_i) begin
          got_pc.push_back(if1.pc_o); got_instr.push_back(if1.instr_o); got_cyc.push_back(cyc);
        end
        if (rsp_budget > 0 && q1.size() > 0) begin
          a = q1.pop_front();
          if1.imem_rvalid_i = 1'b1; if1.imem_rdata_i = mem_word(a); rsp_budget--;
        end else begin
          if1.imem_rvalid_i = 1'b0; if1.imem_rdata_i = '0;
        end
        if (if1.imem_req_o && gnt_budget > 0) begin
          if1.imem_gnt_i = 1'b1; q1.push_back(if1.imem_addr_o);
          gnt_addr.push_back(if1.imem_addr_o); gnt_budget--;
        end else begin
          if1.imem_gnt_i = 1'b0;
        end
      end
    end
  end

  // Zero-wait memory and monitor for dut2 (always ready, never redirected).
  initial begin
    logic [31:0] a;
    if2.imem_gnt_i = 1'b0; if2.imem_rvalid_i = 1'b0; if2.imem_rdata_i = '0;
    if2.redirect_i = 1'b0; if2.redirect_pc_i = '0; if2.instr_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst2_n) begin
        q2.delete();
        if2.imem_gnt_i = 1'b0; if2.imem_rvalid_i = 1'b0; if2.imem_rdata_i = '0;
      end else begin
        if (if2.instr_valid_o) got2_pc.push_back(if2.pc_o);
        if (q2.size() > 0) begin
          a = q2.pop_front();
          if2.imem_rvalid_i = 1'b1; if2.imem_rdata_i = mem_word(a);
        end else begin
          if2.imem_rvalid_i = 1'b0; if2.imem_rdata_i = '0;
        end
        if2.imem_gnt_i = if2.imem_req_o;
        if (if2.imem_req_o) q2.push_back(if2.imem_addr_o);
      end
    end
  end

  task automatic do_reset(input int gb, input int rb);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    gnt_addr.delete(); got_pc.delete(); got_instr.delete(); got_cyc.delete();
    gnt_budget = gb; rsp_budget = rb;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    if1.instr_ready_i = 1'b1; if1.redirect_i = 1'b0; if1.redirect_pc_i = '0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (if1.imem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", if1.imem_req_o); end
    checks++; if (if1.instr_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", if1.instr_valid_o); end
    checks++; if (if1.instr_o !== 32'h0 || if1.pc_o !== 32'h0) begin failures++; $display("FAIL reset_data: instr %h pc %h expected 0", if1.instr_o, if1.pc_o); end
    gnt_addr.delete(); got_pc.delete(); got_instr.delete(); got_cyc.delete();
    gnt_budget = 1000; rsp_budget = 1000;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (gnt_addr.size() < 1 || gnt_addr[0] !== 32'h0) begin failures++; $display("FAIL first_addr: got %0d grants expected first at 00000000", gnt_addr.size()); end
    checks++;
    if (got_pc.size() < 4) begin
      failures++; $display("FAIL seq_count: got %0d expected >=4", got_pc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (got_pc[i] !== exp_pc[i]) begin failures++; $display("FAIL seq_pc%0d: got %h expected %h", i, got_pc[i], exp_pc[i]); end
        checks++; if (got_instr[i] !== mem_word(exp_pc[i])) begin failures++; $display("FAIL seq_instr%0d: got %h expected %h", i, got_instr[i], mem_word(exp_pc[i])); end
      end
      for (int i = 0; i < 3; i++) begin
        checks++; if (got_cyc[i+1] - got_cyc[i] !== 1) begin failures++; $display("FAIL seq_rate%0d: got gap %0d expected 1", i, got_cyc[i+1] - got_cyc[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    if1.instr_ready_i = 1'b0;
    do_reset(1000, 1000);
    repeat (12) @(posedge clk);
    #1;
    checks++; if (gnt_addr.size() !== 4) begin failures++; $display("FAIL bp_grants: got %0d expected 4", gnt_addr.size()); end
    checks++; if (if1.imem_req_o !== 1'b0) begin failures++; $display("FAIL bp_req_low: got %b expected 0", if1.imem_req_o); end
    checks++; if (if1.instr_valid_o !== 1'b1 || if1.pc_o !== 32'h0) begin failures++; $display("FAIL bp_head: valid %b pc %h expected 1 00000000", if1.instr_valid_o, if1.pc_o); end
    if1.instr_ready_i = 1'b1;
    @(posedge clk); #1;
    if1.instr_ready_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (gnt_addr.size() !== 5) begin failures++; $display("FAIL bp_one_more: got %0d grants expected 5", gnt_addr.size()); end
    checks++; if (gnt_addr.size() < 5 || gnt_addr[4] !== 32'h10) begin failures++; $display("FAIL bp_addr: got %0d grants expected fifth at 00000010", gnt_addr.size()); end
    checks++; if (if1.imem_req_o !== 1'b0 || if1.pc_o !== 32'h4) begin failures++; $display("FAIL bp_after_pop: req %b pc %h expected 0 00000004", if1.imem_req_o, if1.pc_o); end
  endtask

  task automatic test_gnt_stall();
    if1.instr_ready_i = 1'b1;
    do_reset(2, 1000);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (gnt_addr.size() !== 2) begin failures++; $display("FAIL stall_grants: got %0d expected 2", gnt_addr.size()); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (if1.imem_req_o !== 1'b1 || if1.imem_addr_o !== 32'h8) begin failures++; $display("FAIL stall_hold%0d: req %b addr %h expected 1 00000008", k, if1.imem_req_o, if1.imem_addr_o); end
      @(posedge clk); #1;
    end
    gnt_budget = 1000;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (got_pc.size() < 4 || got_pc[2] !== 32'h8 || got_pc[3] !== 32'hC) begin failures++; $display("FAIL stall_resume: got %0d entries expected pcs 8 and C at 2,3", got_pc.size()); end
  endtask

  task automatic test_redirect_inflight();
    int stale;
    if1.instr_ready_i = 1'b1;
    do_reset(6, 4);
    repeat (14) @(posedge clk);
    #1;
    checks++; if (got_pc.size() !== 4 || gnt_addr.size() !== 6) begin failures++; $display("FAIL rd_setup: got %0d out %0d grants expected 4 6", got_pc.size(), gnt_addr.size()); end
    if1.redirect_i = 1'b1; if1.redirect_pc_i = 32'h103;
    gnt_budget = 1000; rsp_budget = 1000;
    @(posedge clk); #1;
    if1.redirect_i = 1'b0;
    checks++; if (if1.instr_valid_o !== 1'b0) begin failures++; $display("FAIL rd_valid_r1: got %b expected 0", if1.instr_valid_o); end
    repeat (12) @(posedge clk);
    #1;
    checks++; if (got_pc.size() < 6 || got_pc[4] !== 32'h100 || got_pc[5] !== 32'h104) begin failures++; $display("FAIL rd_target: got %0d entries expected pcs 100,104 at 4,5", got_pc.size()); end
    checks++; if (got_instr.size() < 5 || got_instr[4] !== mem_word(32'h100)) begin failures++; $display("FAIL rd_instr: got %0d entries expected word for 100 at 4", got_instr.size()); end
    stale = 0;
    foreach (got_pc[i]) if (got_pc[i] == 32'h10 || got_pc[i] == 32'h14) stale++;
    checks++; if (stale !== 0) begin failures++; $display("FAIL rd_stale: got %0d stale entries expected 0", stale); end
  endtask

  task automatic test_redirect_pending();
    if1.instr_ready_i = 1'b1;
    do_reset(8, 1000);
    repeat (16) @(posedge clk);
    #1;
    checks++; if (got_pc.size() !== 8 || if1.imem_req_o !== 1'b1 || if1.imem_addr_o !== 32'h20) begin failures++; $display("FAIL rp_setup: entries %0d req %b addr %h expected 8 1 00000020", got_pc.size(), if1.imem_req_o, if1.imem_addr_o); end
    if1.redirect_i = 1'b1; if1.redirect_pc_i = 32'h200;
    @(posedge clk); #1;
    if1.redirect_i = 1'b0;
    checks++; if (if1.imem_req_o !== 1'b1 || if1.imem_addr_o !== 32'h20) begin failures++; $display("FAIL rp_hold: req %b addr %h expected 1 00000020", if1.imem_req_o, if1.imem_addr_o); end
    gnt_budget = 1000;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (gnt_addr.size() < 10 || gnt_addr[8] !== 32'h20 || gnt_addr[9] !== 32'h200) begin failures++; $display("FAIL rp_order: got %0d grants expected 00000020 then 00000200 at 8,9", gnt_addr.size()); end
    checks++; if (got_pc.size() < 9 || got_pc[8] !== 32'h200) begin failures++; $display("FAIL rp_first: got %0d entries expected pc 00000200 at 8", got_pc.size()); end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] exp_pc [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    @(posedge clk); #1;
    got2_pc.delete();
    rst2_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (got2_pc.size() < 4) begin
      failures++; $display("FAIL wrap_count: got %0d expected >=4", got2_pc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (got2_pc[i] !== exp_pc[i]) begin failures++; $display("FAIL wrap_pc%0d: got %h expected %h", i, got2_pc[i], exp_pc[i]); end
      end
    end
    checks++; if (if2.instr_valid_o !== 1'b1) begin failures++; $display("FAIL wrap_streaming: got %b expected 1", if2.instr_valid_o); end
    @(posedge clk); #3;
    rst2_n = 1'b0;
    #1;
    checks++; if (if2.imem_req_o !== 1'b0 || if2.instr_valid_o !== 1'b0) begin failures++; $display("FAIL async_ctrl: req %b valid %b expected 0 0", if2.imem_req_o, if2.instr_valid_o); end
    checks++; if (if2.instr_o !== 32'h0 || if2.pc_o !== 32'h0) begin failures++; $display("FAIL async_data: instr %h pc %h expected 0 0", if2.instr_o, if2.pc_o); end
    @(posedge clk); #1;
    got2_pc.delete();
    rst2_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (got2_pc.size() < 2 || got2_pc[0] !== 32'hFFFF_FFF8 || got2_pc[1] !== 32'hFFFF_FFFC) begin failures++; $display("FAIL restart: got %0d entries expected FFFFFFF8,FFFFFFFC first", got2_pc.size()); end
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    if1.redirect_i = 1'b0; if1.redirect_pc_i = '0; if1.instr_ready_i = 1'b1;
    test_reset();
    test_backpressure();
    test_gnt_stall();
    test_redirect_inflight();
    test_redirect_pending();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
